// File: rtl/smg_encode_module.sv
// smg_encode_module: double-dabble BCD converter feeding a scanned three-digit
// seven-segment display; committed digits update atomically at conversion end.
`default_nettype none

module smg_encode_module #(
   parameter int NUM_W    = 10,
   parameter int BLANK_LZ = 1,
   parameter int MAX_VAL  = 999
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic [2:0]       Scan_Sig,
   input  logic [NUM_W-1:0] Number_Sig,
   input  logic             Load_Sig,
   output logic             Busy_Sig,
   output logic [7:0]       SMG_Data
);

   localparam int          CNT_W = $clog2(NUM_W + 1);
   localparam logic [31:0] c_MAX = 32'(MAX_VAL);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CONV   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [NUM_W-1:0] r_shift, r_val;
   logic [11:0]      r_scratch, w_adj;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_h, r_t, r_o, w_h, w_t, w_o;
   logic             r_ovf, w_ovf;
   logic             w_load, w_commit;
   logic [7:0]       r_smg, w_smg;

   function automatic logic [7:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    return 8'hC0;
         4'd1:    return 8'hF9;
         4'd2:    return 8'hA4;
         4'd3:    return 8'hB0;
         4'd4:    return 8'h99;
         4'd5:    return 8'h92;
         4'd6:    return 8'h82;
         4'd7:    return 8'hF8;
         4'd8:    return 8'h80;
         4'd9:    return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Loads are only accepted in IDLE, so requests during CONV or COMMIT vanish.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Load_Sig) begin
               w_load      = 1'b1;
               w_state_nxt = S_CONV;
            end
         end
         S_CONV: begin
            if (r_cnt == CNT_W'(1)) w_state_nxt = S_COMMIT;
         end
         S_COMMIT: begin
            w_commit    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign Busy_Sig = (r_state != S_IDLE);

   always_comb begin
      w_adj = r_scratch;
      for (int i = 0; i < 3; i++) begin
         if (r_scratch[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_scratch[i*4 +: 4] + 4'd3;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_shift   <= '0;
         r_val     <= '0;
         r_scratch <= '0;
         r_cnt     <= '0;
      end else if (w_load) begin
         r_shift   <= Number_Sig;
         r_val     <= Number_Sig;
         r_scratch <= '0;
         r_cnt     <= CNT_W'(NUM_W);
      end else if (r_state == S_CONV) begin
         {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
         r_cnt                <= r_cnt - 1'b1;
      end
   end

   // Next committed state feeds the display register so new digits appear
   // the cycle right after COMMIT.
   assign w_h   = w_commit ? r_scratch[11:8] : r_h;
   assign w_t   = w_commit ? r_scratch[7:4]  : r_t;
   assign w_o   = w_commit ? r_scratch[3:0]  : r_o;
   assign w_ovf = w_commit ? (32'(r_val) > c_MAX) : r_ovf;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_h   <= '0;
         r_t   <= '0;
         r_o   <= '0;
         r_ovf <= 1'b0;
      end else begin
         r_h   <= w_h;
         r_t   <= w_t;
         r_o   <= w_o;
         r_ovf <= w_ovf;
      end
   end

   always_comb begin
      w_smg = 8'hFF;
      case (Scan_Sig)
         3'b100: begin
            if (w_ovf)                                 w_smg = 8'hBF;
            else if ((BLANK_LZ != 0) && (w_h == 4'd0)) w_smg = 8'hFF;
            else                                       w_smg = seg_code(w_h);
         end
         3'b010: begin
            if (w_ovf)                                                     w_smg = 8'hBF;
            else if ((BLANK_LZ != 0) && (w_h == 4'd0) && (w_t == 4'd0)) w_smg = 8'hFF;
            else                                                           w_smg = seg_code(w_t);
         end
         3'b001: begin
            if (w_ovf) w_smg = 8'hBF;
            else       w_smg = seg_code(w_o);
         end
         default: w_smg = 8'hFF;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) r_smg <= 8'hFF;
      else       r_smg <= w_smg;
   end

   assign SMG_Data = r_smg;

endmodule

`default_nettype wire

// File: tb/tb_smg_encode_module.sv
// tb_smg_encode_module: table vectors, hand-written corner sequences and
// random loads checked against an arithmetic display model.
`default_nettype none

module tb_smg_encode_module;

   localparam int NUM_W = 10;

   logic             CLK = 1'b0;
   logic             RSTn = 1'b0;
   logic [2:0]       Scan_Sig = 3'b001;
   logic [NUM_W-1:0] Number_Sig = '0;
   logic             Load_Sig = 1'b0;
   logic             Busy_Sig;
   logic [7:0]       SMG_Data;

   int checks   = 0;
   int failures = 0;
   int cur_val  = 0;

   typedef struct {
      int         val;
      logic [7:0] h;
      logic [7:0] t;
      logic [7:0] o;
   } vec_t;

   vec_t vecs[10];

   always #5 CLK = ~CLK;

   smg_encode_module #(.NUM_W(NUM_W), .BLANK_LZ(1), .MAX_VAL(999)) u_dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .Scan_Sig   (Scan_Sig),
      .Number_Sig (Number_Sig),
      .Load_Sig   (Load_Sig),
      .Busy_Sig   (Busy_Sig),
      .SMG_Data   (SMG_Data)
   );

   function automatic logic [7:0] digit_code(input int d);
      case (d)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  9: return 8'h90;
         default: return 8'h00;
      endcase
   endfunction

   // Display model computed directly from decimal digits of the value.
   function automatic logic [7:0] exp_seg(input int v, input logic [2:0] s);
      int h, t, o;
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      if (s != 3'b100 && s != 3'b010 && s != 3'b001) return 8'hFF;
      if (v > 999) return 8'hBF;
      if (s == 3'b100) return (h == 0) ? 8'hFF : digit_code(h);
      if (s == 3'b010) return (h == 0 && t == 0) ? 8'hFF : digit_code(t);
      return digit_code(o);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic scan_show(input logic [2:0] s, input logic [7:0] exp, input string name);
      Scan_Sig = s;
      @(negedge CLK);
      check(name, SMG_Data, exp);
   endtask

   // Load v; optionally pulse a second load at busy cycle p_cyc.
   task automatic load_val(input int v, input int p_cyc, input int p_val);
      int n;
      n = 0;
      Scan_Sig   = 3'b001;
      Number_Sig = NUM_W'(v);
      Load_Sig   = 1'b1;
      @(negedge CLK);
      Load_Sig = 1'b0;
      for (int c = 1; c < 40; c++) begin
         if (!Busy_Sig) begin
            Load_Sig = 1'b0;
            break;
         end
         n++;
         if (c == p_cyc) begin
            Load_Sig   = 1'b1;
            Number_Sig = NUM_W'(p_val);
         end else begin
            Load_Sig = 1'b0;
         end
         @(negedge CLK);
      end
      Load_Sig = 1'b0;
      check("busy_cycles", n, 11);
      check("first_cycle_digit", SMG_Data, exp_seg(v, 3'b001));
      cur_val = v;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{123,  8'hF9, 8'hA4, 8'hB0};
      vecs[1] = '{7,    8'hFF, 8'hFF, 8'hF8};
      vecs[2] = '{40,   8'hFF, 8'h99, 8'hC0};
      vecs[3] = '{905,  8'h90, 8'hC0, 8'h92};
      vecs[4] = '{1000, 8'hBF, 8'hBF, 8'hBF};
      vecs[5] = '{1023, 8'hBF, 8'hBF, 8'hBF};
      vecs[6] = '{999,  8'h90, 8'h90, 8'h90};
      vecs[7] = '{0,    8'hFF, 8'hFF, 8'hC0};
      vecs[8] = '{100,  8'hF9, 8'hC0, 8'hC0};
      vecs[9] = '{10,   8'hFF, 8'hF9, 8'hC0};

      repeat (3) @(negedge CLK);
      check("rst_busy", Busy_Sig, 0);
      check("rst_smg", SMG_Data, 8'hFF);
      RSTn = 1'b1;
      @(negedge CLK);
      scan_show(3'b100, 8'hFF, "rst_h");
      scan_show(3'b010, 8'hFF, "rst_t");
      scan_show(3'b001, 8'hC0, "rst_o");
      check("rst_busy_after", Busy_Sig, 0);

      foreach (vecs[i]) begin
         load_val(vecs[i].val, -1, 0);
         Scan_Sig = 3'b100;
         #1;
         check("scan_lag", SMG_Data, vecs[i].o);
         @(negedge CLK);
         check("vec_h", SMG_Data, vecs[i].h);
         scan_show(3'b010, vecs[i].t, "vec_t");
         scan_show(3'b001, vecs[i].o, "vec_o");
      end

      load_val(456, 5, 789);
      scan_show(3'b100, 8'h99, "busy_load_h");
      scan_show(3'b010, 8'h92, "busy_load_t");
      scan_show(3'b001, 8'h82, "busy_load_o");

      load_val(612, 11, 222);
      check("commit_load_busy", Busy_Sig, 0);
      scan_show(3'b100, 8'h82, "commit_load_h");
      check("commit_load_idle", Busy_Sig, 0);
      scan_show(3'b010, 8'hF9, "commit_load_t");
      scan_show(3'b001, 8'hA4, "commit_load_o");

      Scan_Sig   = 3'b001;
      Number_Sig = NUM_W'(321);
      Load_Sig   = 1'b1;
      @(negedge CLK);
      Load_Sig = 1'b0;
      repeat (3) @(negedge CLK);
      RSTn = 1'b0;
      @(negedge CLK);
      check("midrst_busy", Busy_Sig, 0);
      check("midrst_smg", SMG_Data, 8'hFF);
      RSTn = 1'b1;
      repeat (14) @(negedge CLK);
      check("midrst_no_resume", Busy_Sig, 0);
      cur_val = 0;
      scan_show(3'b100, 8'hFF, "midrst_h");
      scan_show(3'b010, 8'hFF, "midrst_t");
      scan_show(3'b001, 8'hC0, "midrst_o");
      scan_show(3'b000, 8'hFF, "scan_none");
      scan_show(3'b110, 8'hFF, "scan_multi");

      for (int r = 0; r < 25; r++) begin
         load_val(int'($urandom_range(0, 1023)), -1, 0);
         for (int k = 0; k < 4; k++) begin
            logic [2:0] s;
            s = 3'($urandom_range(0, 7));
            scan_show(s, exp_seg(cur_val, s), "rand_scan");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
